mem_stage_sb: RTL and testbench

- Parametrised successor to the single-cycle data-memory stage.
- Sits between EX/MEM and MEM/WB. Fronts a multi-cycle data memory through a req/done handshake.
- Stores retire into a DEPTH-entry store buffer without stalling, and drain in the background.
- Loads forward from the youngest matching buffer entry, or issue to memory and stall until done.

---
 rtl/mem_stage_sb_pkg.sv | 20 ++
 rtl/mem_stage_sb_fifo.sv | 101 ++++++++++
 rtl/mem_stage_sb.sv | 156 +++++++++++++++
 tb/tb_mem_stage_sb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sb_pkg.sv
// Shared types for the buffered data-memory stage.
//   state_e : memory-port FSM state (IDLE / DRAIN / LOAD)
//   cnt_w() : width of the store-buffer occupancy count for a given depth.
//             It is one bit wider than the pointers so that a full buffer can be told
//             apart from an empty one.
// The store-buffer entry struct {addr, data} is declared inside sb_fifo.
// Its field widths follow the module parameters, and a package cannot be parameterised.
package mem_stage_sb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_stage_sb_fifo.sv
// sb_fifo: circular store buffer with a parallel, youngest-first address lookup.
//   clk, rst               : clock, async active-high reset (empties the buffer)
//   push, push_addr/data   : append an entry at the tail. A push is accepted when the
//                            buffer is not full, or when a pop happens in the same cycle.
//   pop                    : drop the head entry (ignored when empty)
//   head_addr/head_data    : oldest entry
//   full, empty, count     : occupancy
//   lk_addr -> lk_hit/data : youngest valid entry whose address equals lk_addr
module sb_fifo
  import mem_stage_sb_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [AW-1:0]             push_addr,
  input  logic [DW-1:0]             push_data,
  input  logic                      pop,
  output logic [AW-1:0]             head_addr,
  output logic [DW-1:0]             head_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  input  logic [AW-1:0]             lk_addr,
  output logic                      lk_hit,
  output logic [DW-1:0]             lk_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               do_push, do_pop;
  logic [PW-1:0]      idx;

  always_comb begin
    do_pop  = pop & (cnt_q != '0);
    do_push = push & ((cnt_q != CW'(DEPTH)) | do_pop);
    ent_d   = ent_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    // DEPTH is a power of two, so the pointers wrap naturally.
    if (do_push) begin
      ent_d[wr_q] = '{addr: push_addr, data: push_data};
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Scan from the oldest entry to the youngest. A later match overrides an earlier one,
  // so the youngest matching store wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_q + PW'(k);
      if ((CW'(k) < cnt_q) && (ent_q[idx].addr == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = ent_q[idx].data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_addr = ent_q[rd_q].addr;
  assign head_data = ent_q[rd_q].data;
  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;

endmodule

// File: rtl/mem_stage_sb.sv
// mem_stage_sb: MEM pipeline stage fronting a multi-cycle data memory.
// Stores retire into a store buffer and drain in the background.
// Loads forward from the buffer, or stall for a memory read.
//   in_*      : EX/MEM instruction fields
//   wb_*      : MEM/WB writeback fields. stall holds the upstream pipeline.
//   err       : pulses for a load error, and stays set after any store-drain error
//   sb_count  : store-buffer occupancy
//   mem_*     : req/done handshake. The request fields are registered and held until done.
module mem_stage_sb
  import mem_stage_sb_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 4,
  parameter int RW    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_rd,
  input  logic                     in_wr,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_alu,
  input  logic [DW-1:0]            in_wdata,
  input  logic                     in_memtoreg,
  input  logic                     in_regwrite,
  input  logic [RW-1:0]            in_rdaddr,
  input  logic                     in_dump,
  output logic [DW-1:0]            wb_data,
  output logic                     wb_regwrite,
  output logic [RW-1:0]            wb_rdaddr,
  output logic                     wb_dump,
  output logic                     stall,
  output logic                     err,
  output logic [cnt_w(DEPTH)-1:0]  sb_count,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_done,
  input  logic                     mem_err
);

  state_e        state_q, state_d;
  logic          we_q, we_d, sticky_q, sticky_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          is_ld, is_st, is_dump, ld_miss;
  logic          drain_done, load_done, push;
  logic          hit, full, empty;
  logic [DW-1:0] hit_data, head_data;
  logic [AW-1:0] head_addr;

  sb_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (in_addr),
    .push_data (in_wdata),
    .pop       (drain_done),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (sb_count),
    .lk_addr   (in_addr),
    .lk_hit    (hit),
    .lk_data   (hit_data)
  );

  // Datapath, handshake qualifiers and stall.
  always_comb begin
    is_ld      = in_valid & in_rd;
    is_st      = in_valid & in_wr;
    is_dump    = in_valid & in_dump;
    ld_miss    = is_ld & ~hit;
    // mem_done outside DRAIN/LOAD is a protocol violation and is ignored.
    drain_done = mem_done & (state_q == ST_DRAIN);
    load_done  = mem_done & (state_q == ST_LOAD);
    // A full buffer still accepts a store in the cycle the head drain completes.
    push       = is_st & (~full | drain_done);
    stall      = (is_st & full & ~drain_done)
               | (ld_miss & ~load_done)
               | (is_dump & ~(empty & (state_q == ST_IDLE)));
    if (is_ld & in_memtoreg) wb_data = hit ? hit_data : mem_rdata;
    else                     wb_data = in_alu;
    wb_regwrite = in_regwrite & in_valid & ~stall;
    wb_rdaddr   = in_rdaddr;
    wb_dump     = in_dump & ~stall;
    sticky_d    = sticky_q | (drain_done & mem_err);
    err         = sticky_q | (load_done & mem_err);
  end

  // Port FSM. A pending load miss outranks further drains. This holds even at the end of
  // a drain, so the load is issued the very next cycle.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_miss) begin
          state_d = ST_LOAD;
          we_d    = 1'b0;
          addr_d  = in_addr;
        end else if (!empty) begin
          state_d = ST_DRAIN;
          we_d    = 1'b1;
          addr_d  = head_addr;
          wdata_d = head_data;
        end
      end
      ST_DRAIN: begin
        if (mem_done) begin
          if (ld_miss) begin
            state_d = ST_LOAD;
            we_d    = 1'b0;
            addr_d  = in_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOAD: if (mem_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sticky_q <= sticky_d;
    end
  end

  assign mem_req   = (state_q != ST_IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // The memory must not complete a request that was never issued.
  a_done_needs_req: assert property (@(posedge clk) disable iff (rst) mem_done |-> mem_req);

endmodule

// File: tb/tb_mem_stage_sb.sv
module tb_mem_stage_sb;
  localparam int DW = 16, AW = 16, DEPTH = 4, RW = 3;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 0, in_rd = 0, in_wr = 0, in_memtoreg = 0, in_regwrite = 0, in_dump = 0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_alu = '0, in_wdata = '0;
  logic [RW-1:0] in_rdaddr = '0;
  logic [DW-1:0] wb_data;
  logic wb_regwrite, wb_dump, stall, err, mem_req, mem_we;
  logic [RW-1:0] wb_rdaddr;
  logic [CW-1:0] sb_count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_done = 1'b0, mem_err = 1'b0;

  mem_stage_sb #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rd(in_rd), .in_wr(in_wr),
    .in_addr(in_addr), .in_alu(in_alu), .in_wdata(in_wdata), .in_memtoreg(in_memtoreg),
    .in_regwrite(in_regwrite), .in_rdaddr(in_rdaddr), .in_dump(in_dump),
    .wb_data(wb_data), .wb_regwrite(wb_regwrite), .wb_rdaddr(wb_rdaddr), .wb_dump(wb_dump),
    .stall(stall), .err(err), .sb_count(sb_count), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int last_stalls;
  logic [CW-1:0] first_cnt;

  // dev: contents of the memory device. arch: program-order view (last store wins).
  logic [DW-1:0] dev  [logic [AW-1:0]];
  logic [DW-1:0] arch [logic [AW-1:0]];
  int lat = 0, rcnt = -1;
  bit drain_err_nxt = 0, load_err_nxt = 0;
  logic          log_we[$];
  logic [AW-1:0] log_addr[$];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] arch_val(input logic [AW-1:0] a);
    return arch.exists(a) ? arch[a] : init_val(a);
  endfunction

  // Memory device: responds `lat` cycles after it sees a request, with a one-cycle done pulse.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      rcnt = -1; mem_done = 0; mem_err = 0;
    end else if (mem_done) begin
      mem_done = 0; mem_err = 0; rcnt = -1;
    end else if (mem_req) begin
      if (rcnt < 0) begin
        rcnt = lat;
        log_we.push_back(mem_we);
        log_addr.push_back(mem_addr);
      end
      if (rcnt == 0) begin
        mem_done = 1; mem_err = 0;
        if (mem_we) begin
          dev[mem_addr] = mem_wdata;
          if (drain_err_nxt) begin mem_err = 1; drain_err_nxt = 0; end
        end else begin
          mem_rdata = dev.exists(mem_addr) ? dev[mem_addr] : init_val(mem_addr);
          if (load_err_nxt) begin mem_err = 1; load_err_nxt = 0; end
        end
        rcnt = -1;
      end else rcnt--;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction and hold it until the stage stops stalling.
  // The task returns at the negedge of the cycle in which the instruction completes.
  task automatic run_instr(input logic rd, input logic wr, input logic dump,
                           input logic m2r, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                           input logic [RW-1:0] rda);
    @(posedge clk) #1;
    in_valid = 1; in_rd = rd; in_wr = wr; in_dump = dump; in_memtoreg = m2r;
    in_regwrite = rw; in_addr = a; in_alu = alu; in_wdata = wd; in_rdaddr = rda;
    last_stalls = 0;
    @(negedge clk);
    first_cnt = sb_count;
    while (stall && last_stalls < 300) begin
      last_stalls++;
      @(negedge clk);
    end
    if (stall) chk("stall_timeout", 32'(stall), 32'd0);
  endtask

  task automatic idle(input int n);
    @(posedge clk) #1;
    in_valid = 0; in_rd = 0; in_wr = 0; in_dump = 0; in_regwrite = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    idle(1);
    k = 0;
    while ((sb_count != '0 || mem_req) && k < 500) begin k++; @(negedge clk); end
    chk("drain_wait", 32'(sb_count == '0 && !mem_req), 32'd1);
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    run_instr(0, 1, 0, 0, 0, a, 16'h0, d, 3'd0);
    chk("st_regwrite", 32'(wb_regwrite), 32'd0);
    arch[a] = d;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [RW-1:0] rda);
    run_instr(1, 0, 0, 1, 1, a, ~a, 16'h0, rda);
    chk("ld_data", 32'(wb_data), 32'(arch_val(a)));
    chk("ld_regwrite", 32'(wb_regwrite), 32'd1);
    chk("ld_rdaddr", 32'(wb_rdaddr), 32'(rda));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dump", 32'(wb_dump), 32'd0);
    @(negedge clk) rst = 0;

    // Four stores fill the buffer without stalling. The fifth waits for the first drain.
    lat = 5; log_we.delete(); log_addr.delete();
    for (int i = 0; i < 4; i++) begin
      do_store(AW'(16'h10 + i), DW'(16'hA0 + i));
      chk("fill_nostall", 32'(last_stalls), 32'd0);
      chk("fill_count", 32'(first_cnt), 32'(i));
    end
    do_store(16'h14, 16'hA4);
    chk("full_cnt_before", 32'(first_cnt), 32'd4);
    chk("full_stalled", 32'(last_stalls > 0), 32'd1);
    idle(1);
    chk("full_cnt_after", 32'(sb_count), 32'd4);
    chk("drain0_we", 32'(log_we[0]), 32'd1);
    chk("drain0_addr", 32'(log_addr[0]), 32'h10);
    wait_idle();

    // Forwarding from the youngest of two stores to the same address.
    lat = 8; log_we.delete(); log_addr.delete();
    dev[16'h40] = 16'hBEEF; arch[16'h40] = 16'hBEEF;
    do_store(16'h20, 16'h1111);
    do_store(16'h20, 16'h2222);
    do_load(16'h20, 3'd1);
    chk("fwd_nostall", 32'(last_stalls), 32'd0);
    chk("fwd_data", 32'(wb_data), 32'h2222);
    // A load miss during an outstanding drain waits, then goes out right after that drain.
    do_load(16'h40, 3'd2);
    chk("miss_stalled", 32'(last_stalls > 0), 32'd1);
    chk("miss_data", 32'(wb_data), 32'hBEEF);
    chk("miss_logs", 32'(log_we.size() >= 2), 32'd1);
    if (log_we.size() >= 2) begin
      chk("miss_req_we", 32'(log_we[log_we.size()-1]), 32'd0);
      chk("miss_req_addr", 32'(log_addr[log_addr.size()-1]), 32'h40);
      chk("miss_prev_drain", 32'(log_we[log_we.size()-2]), 32'd1);
    end
    wait_idle();

    // Error reporting: a load error pulses, and a drain error stays set.
    lat = 1;
    load_err_nxt = 1;
    do_load(16'h41, 3'd3);
    chk("ld_err_pulse", 32'(err), 32'd1);
    idle(1);
    chk("ld_err_clear", 32'(err), 32'd0);
    drain_err_nxt = 1;
    do_store(16'h42, 16'h4242);
    wait_idle();
    chk("drain_err_set", 32'(err), 32'd1);
    idle(5);
    chk("drain_err_hold", 32'(err), 32'd1);

    // A dump waits for three buffered stores to drain, then wb_dump is high for one cycle.
    lat = 3;
    for (int i = 0; i < 3; i++) do_store(AW'(16'h50 + i), DW'(16'h5000 + i));
    run_instr(0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0);
    chk("dump_stalled", 32'(last_stalls > 0), 32'd1);
    chk("dump_pulse", 32'(wb_dump), 32'd1);
    chk("dump_count", 32'(sb_count), 32'd0);
    chk("dump_noreq", 32'(mem_req), 32'd0);
    idle(1);
    chk("dump_once", 32'(wb_dump), 32'd0);
    chk("dump_ld_err", 32'(err), 32'd1);

    // An asynchronous reset during an outstanding drain drops the request and the buffer.
    lat = 20;
    do_store(16'h70, 16'h7777);
    idle(1);
    for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
    chk("rst_pre_req", 32'(mem_req), 32'd1);
    #2 rst = 1;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_count", 32'(sb_count), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    arch.delete(16'h70);
    repeat (2) @(negedge clk);
    rst = 0;
    lat = 2; log_we.delete(); log_addr.delete();
    do_load(16'h60, 3'd4);
    chk("post_rst_req_we", 32'(log_we.size() == 1 && log_we[0] == 1'b0), 32'd1);
    chk("post_rst_req_addr", 32'(log_addr.size() == 1 && log_addr[0] == 16'h60), 32'd1);

    // Randomised mix checked against the program-order memory view.
    for (int n = 0; n < 150; n++) begin
      int sel;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic rw;
      sel = int'($urandom_range(0, 9));
      a   = AW'($urandom_range(0, 7));
      d   = DW'($urandom);
      rw  = 1'($urandom);
      lat = int'($urandom_range(0, 3));
      if (sel < 4) begin
        do_store(a, d);
      end else if (sel < 7) begin
        do_load(a, RW'($urandom));
      end else if (sel < 9) begin
        run_instr(0, 0, 0, 0, rw, a, d, 16'h0, 3'd5);
        chk("alu_data", 32'(wb_data), 32'(d));
        chk("alu_regwrite", 32'(wb_regwrite), 32'(rw));
        chk("alu_nostall", 32'(last_stalls), 32'd0);
      end else begin
        idle(int'($urandom_range(1, 3)));
      end
      chk("rnd_err", 32'(err), 32'd0);
      chk("rnd_cnt_bound", 32'(sb_count <= CW'(DEPTH)), 32'd1);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
